// File: rtl/bsg_popcount.sv
// Combinational population count of one lane slice.
// Ports: data_i (width_p bits in), count_o (number of set bits out).
module bsg_popcount #(
  parameter int width_p = 8,
  localparam int cnt_w_lp = $clog2(width_p + 1)
) (
  input  logic [width_p-1:0]  data_i,
  output logic [cnt_w_lp-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < width_p; i++)
      count_o = count_o + cnt_w_lp'(data_i[i]);
  end

endmodule

// File: rtl/bsg_popcount_stream.sv
// Streaming per-frame popcount: lane counters, accumulator, result register.
// Ports: clk_i, reset_i (async high), v_i/data_i/last_i/ready_o beat input,
// v_o/count_o/sat_o/yumi_i frame result output.
module bsg_popcount_stream #(
  parameter int width_p     = 32,
  parameter int lanes_p     = 4,
  parameter int acc_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [acc_width_p-1:0] count_o,
  output logic                   sat_o,
  input  logic                   yumi_i
);

  localparam int lane_w_lp     = width_p / lanes_p;
  localparam int lane_cnt_w_lp = $clog2(lane_w_lp + 1);
  localparam int sum_w_lp      = $clog2(width_p + 1);
  localparam int ext_w_lp      = acc_width_p + 1;
  localparam logic [ext_w_lp-1:0] max_ext_lp =
    {1'b0, {acc_width_p{1'b1}}};

  logic [lane_cnt_w_lp-1:0] lane_cnt [lanes_p];
  logic [lane_cnt_w_lp-1:0] s1_cnt   [lanes_p];
  logic                     s1_v;
  logic                     s1_last;

  logic [acc_width_p-1:0] acc;
  logic                   acc_sat;

  logic                   accept;
  logic                   advance;
  logic [sum_w_lp-1:0]    lane_sum;
  logic [ext_w_lp-1:0]    total;
  logic                   over;
  logic [acc_width_p-1:0] next_acc;

  for (genvar g = 0; g < lanes_p; g++) begin : g_lane
    bsg_popcount #(.width_p(lane_w_lp)) u_pc (
      .data_i  (data_i[g*lane_w_lp +: lane_w_lp]),
      .count_o (lane_cnt[g])
    );
  end

  // A last beat may only leave stage 1 if the result slot is free
  // or being emptied this cycle.
  assign advance = s1_v & (~s1_last | ~v_o | yumi_i);
  assign ready_o = ~s1_v | advance;
  assign accept  = v_i & ready_o;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < lanes_p; i++)
      lane_sum = lane_sum + sum_w_lp'(s1_cnt[i]);
  end

  // One spare bit so a wrap can be seen before it happens.
  assign total    = {1'b0, acc} + ext_w_lp'(lane_sum);
  assign over     = acc_sat | (total > max_ext_lp);
  assign next_acc = over ? {acc_width_p{1'b1}}
                         : total[acc_width_p-1:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      for (int i = 0; i < lanes_p; i++)
        s1_cnt[i] <= '0;
    end else if (accept) begin
      s1_v    <= 1'b1;
      s1_last <= last_i;
      for (int i = 0; i < lanes_p; i++)
        s1_cnt[i] <= lane_cnt[i];
    end else if (advance) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc     <= '0;
      acc_sat <= 1'b0;
      v_o     <= 1'b0;
      count_o <= '0;
      sat_o   <= 1'b0;
    end else begin
      if (advance & s1_last) begin
        count_o <= next_acc;
        sat_o   <= over;
        v_o     <= 1'b1;
        acc     <= '0;
        acc_sat <= 1'b0;
      end else begin
        if (advance) begin
          acc     <= next_acc;
          acc_sat <= over;
        end
        if (yumi_i)
          v_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bsg_popcount_stream.sv
// Self-checking bench for bsg_popcount_stream (acc widths 16 and 8).
// Scoreboard queues filled at drive time, drained on result handshakes.
module tb_bsg_popcount_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  logic        a_v = 0, a_last = 0, a_ready, a_v_o, a_sat, a_yumi;
  logic [31:0] a_d = 0;
  logic [15:0] a_cnt;
  logic        a_auto = 0;

  logic        b_v = 0, b_last = 0, b_ready, b_v_o, b_sat, b_yumi;
  logic [31:0] b_d = 0;
  logic [7:0]  b_cnt;
  logic        b_auto = 1;

  assign a_yumi = a_auto & a_v_o;
  assign b_yumi = b_auto & b_v_o;

  bsg_popcount_stream #(.width_p(32), .lanes_p(4), .acc_width_p(16)) dut_a (
    .clk_i(clk), .reset_i(rst), .v_i(a_v), .data_i(a_d), .last_i(a_last),
    .ready_o(a_ready), .v_o(a_v_o), .count_o(a_cnt), .sat_o(a_sat),
    .yumi_i(a_yumi)
  );

  bsg_popcount_stream #(.width_p(32), .lanes_p(4), .acc_width_p(8)) dut_b (
    .clk_i(clk), .reset_i(rst), .v_i(b_v), .data_i(b_d), .last_i(b_last),
    .ready_o(b_ready), .v_o(b_v_o), .count_o(b_cnt), .sat_o(b_sat),
    .yumi_i(b_yumi)
  );

  int a_q[$];
  int b_q[$];
  int a_pop_cyc[$];
  int a_acc = 0;
  int b_acc = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: saturating per-frame total, packed as {sat, count}.
  task automatic send_a(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    a_v = 1; a_d = d; a_last = l;
    #1;
    while (!a_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!a_ready) check("a_send_timeout", 0, 1);
    @(posedge clk); #1;
    a_v = 0;
    a_acc += $countones(d);
    if (l) begin
      if (a_acc > 65535) a_q.push_back((1 << 16) | 65535);
      else a_q.push_back(a_acc);
      a_acc = 0;
    end
  endtask

  task automatic send_b(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    b_v = 1; b_d = d; b_last = l;
    #1;
    while (!b_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!b_ready) check("b_send_timeout", 0, 1);
    @(posedge clk); #1;
    b_v = 0;
    b_acc += $countones(d);
    if (l) begin
      if (b_acc > 255) b_q.push_back((1 << 16) | 255);
      else b_q.push_back(b_acc);
      b_acc = 0;
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (a_v_o && a_yumi) begin
      if (a_q.size() == 0) check("a_unexpected", 1, 0);
      else begin
        int e;
        e = a_q.pop_front();
        check("a_count", a_cnt, e & 16'hffff);
        check("a_sat", a_sat, (e >> 16) & 1);
      end
      a_pop_cyc.push_back(cyc);
    end
    if (b_v_o && b_yumi) begin
      if (b_q.size() == 0) check("b_unexpected", 1, 0);
      else begin
        int e;
        e = b_q.pop_front();
        check("b_count", b_cnt, e & 16'hffff);
        check("b_sat", b_sat, (e >> 16) & 1);
      end
    end
  end

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("rst_v_o", a_v_o, 0);
    check("rst_ready", a_ready, 1);
    check("rst_count", a_cnt, 0);
    check("rst_sat", a_sat, 0);

    // single full beat, latency 2
    a_auto = 1;
    send_a(32'hFFFF_FFFF, 1);
    check("lat_e0", a_v_o, 0);
    @(posedge clk); #1;
    check("lat_e1", a_v_o, 1);

    // three-beat frame, 4+16+2
    send_a(32'h0000_000F, 0);
    send_a(32'hF0F0_F0F0, 0);
    send_a(32'h8000_0001, 1);
    repeat (3) @(posedge clk);

    // back-pressure with a second last beat queued
    a_auto = 0;
    send_a(32'h0000_00FF, 1);
    repeat (2) @(posedge clk); #1;
    check("stall_v", a_v_o, 1);
    send_a(32'h0000_000F, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_cnt", a_cnt, 8);
      check("stall_ready", a_ready, 0);
    end
    @(negedge clk);
    a_auto = 1;
    @(posedge clk); #1;
    check("rel_v", a_v_o, 1);
    check("rel_cnt", a_cnt, 4);
    repeat (3) @(posedge clk);

    // saturation at acc_width_p=8
    for (int i = 0; i < 9; i++) send_b(32'hFFFF_FFFF, i == 8);
    send_b(32'h0000_0001, 1);
    repeat (4) @(posedge clk);

    // reset mid-frame with a result pending
    a_auto = 0;
    send_a(32'h0000_0007, 1);
    repeat (2) @(posedge clk);
    send_a(32'h0000_0001, 0);
    send_a(32'h0000_0001, 0);
    @(negedge clk);
    check("pre_rst_v", a_v_o, 1);
    rst = 1;
    #1;
    check("mid_rst_v", a_v_o, 0);
    check("mid_rst_ready", a_ready, 1);
    check("mid_rst_cnt", a_cnt, 0);
    a_q.delete();
    a_acc = 0;
    @(negedge clk);
    rst = 0;
    a_auto = 1;
    send_a(32'h0000_0003, 1);
    repeat (4) @(posedge clk);

    // ten back-to-back one-beat frames
    p0 = a_pop_cyc.size();
    for (int i = 0; i < 10; i++)
      send_a(32'((64'd1 << (i + 1)) - 1), 1);
    for (int n = 0; n < 50 && a_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    if (a_pop_cyc.size() >= p0 + 10)
      check("b2b_span", a_pop_cyc[p0+9] - a_pop_cyc[p0], 9);
    else
      check("b2b_pops", a_pop_cyc.size() - p0, 10);

    for (int n = 0; n < 50 && (a_q.size() + b_q.size()) != 0; n++)
      @(negedge clk);
    check("drain_a", a_q.size(), 0);
    check("drain_b", b_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
